// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell codes, winner encodings, scan FSM
// states and the table of the eight winning lines.
package ttt_pkg;

  localparam logic [7:0] CODE_EMPTY = 8'h00;
  localparam logic [7:0] CODE_X     = 8'h01;
  localparam logic [7:0] CODE_O     = 8'h02;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_BOTH = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_EVAL = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Cell indices of each line; entry l drives win_line[l].
  localparam logic [3:0] LINE_CELLS [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/line_eval.sv
// Combinational evaluation of a captured 3x3 board: completed lines,
// winner flags, board-full and illegal-code detection.
module line_eval
  import ttt_pkg::*;
#(
  parameter int unsigned CELL_W = 8
) (
  input  logic [8:0][CELL_W-1:0] cells,
  output logic [7:0]             win_line,
  output logic [1:0]             winner,
  output logic                   board_full,
  output logic                   invalid
);

  // Scan all cells and all lines; illegal codes never complete a line.
  always_comb begin
    win_line   = '0;
    winner     = WIN_NONE;
    board_full = 1'b1;
    invalid    = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (cells[i] == CELL_W'(CODE_EMPTY)) begin
        board_full = 1'b0;
      end
      if (cells[i] != CELL_W'(CODE_EMPTY) && cells[i] != CELL_W'(CODE_X) &&
          cells[i] != CELL_W'(CODE_O)) begin
        invalid = 1'b1;
      end
    end
    for (int l = 0; l < 8; l++) begin
      if (cells[LINE_CELLS[l][0]] == cells[LINE_CELLS[l][1]] &&
          cells[LINE_CELLS[l][1]] == cells[LINE_CELLS[l][2]]) begin
        if (cells[LINE_CELLS[l][0]] == CELL_W'(CODE_X)) begin
          win_line[l] = 1'b1;
          winner[0]   = 1'b1;
        end else if (cells[LINE_CELLS[l][0]] == CELL_W'(CODE_O)) begin
          win_line[l] = 1'b1;
          winner[1]   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/board_scan_ctrl.sv
// Board scan sequencer: walks the 9:1 cell mux select, captures a shadow
// board, then registers the line evaluation results with a done pulse.
// Optional build macro BOARD_SCAN_AUTO_SCAN_EN adds a free-running rescan
// timer of SCAN_PERIOD cycles.
module board_scan_ctrl
  import ttt_pkg::*;
#(
  parameter int unsigned CELL_W = 8
`ifdef BOARD_SCAN_AUTO_SCAN_EN
  ,
  parameter int unsigned SCAN_PERIOD = 1000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CELL_W-1:0] cell_data,
  output logic [3:0]        sel,
  output logic              busy,
  output logic              done,
  output logic [1:0]        winner,
  output logic [7:0]        win_line,
  output logic              board_full,
  output logic              invalid
);

  state_t                  state;
  logic [8:0][CELL_W-1:0]  shadow;
  logic [7:0]              eval_line;
  logic [1:0]              eval_winner;
  logic                    eval_full;
  logic                    eval_invalid;
  logic                    scan_req;

`ifdef BOARD_SCAN_AUTO_SCAN_EN
  localparam int unsigned CNT_W = $clog2(SCAN_PERIOD);

  logic [CNT_W-1:0] period_cnt;

  // Free-running countdown; runs in every state and reloads on expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= CNT_W'(SCAN_PERIOD - 1);
    end else if (period_cnt == '0) begin
      period_cnt <= CNT_W'(SCAN_PERIOD - 1);
    end else begin
      period_cnt <= period_cnt - 1'b1;
    end
  end

  // Expiry only matters in IDLE; the FSM ignores it elsewhere.
  assign scan_req = start | (period_cnt == '0);
`else
  assign scan_req = start;
`endif

  line_eval #(
    .CELL_W (CELL_W)
  ) u_line_eval (
    .cells      (shadow),
    .win_line   (eval_line),
    .winner     (eval_winner),
    .board_full (eval_full),
    .invalid    (eval_invalid)
  );

  // Scan FSM: capture nine cells, then latch results and pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel        <= 4'd0;
      done       <= 1'b0;
      winner     <= WIN_NONE;
      win_line   <= '0;
      board_full <= 1'b0;
      invalid    <= 1'b0;
      shadow     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          sel <= 4'd0;
          if (scan_req) begin
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          shadow[sel] <= cell_data;
          if (sel == 4'd8) begin
            sel   <= 4'd0;
            state <= ST_EVAL;
          end else begin
            sel <= sel + 4'd1;
          end
        end
        ST_EVAL: begin
          winner     <= eval_winner;
          win_line   <= eval_line;
          board_full <= eval_full;
          invalid    <= eval_invalid;
          done       <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          sel   <= 4'd0;
        end
      endcase
    end
  end

  // Busy covers capture and evaluation only.
  assign busy = (state == ST_SCAN) || (state == ST_EVAL);

endmodule

// File: tb/tb_board_scan_ctrl.sv
// Self-checking bench for board_scan_ctrl (default build, no auto-rescan).
// Boards are held in a bench array and served through a mux model on sel;
// expected results come from a line-by-line reference model.
module tb_board_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] cell_data;
  logic [3:0] sel;
  logic       busy;
  logic       done;
  logic [1:0] winner;
  logic [7:0] win_line;
  logic       board_full;
  logic       invalid;

  logic [7:0] board [9];

  int n_checks;
  int n_pass;

  typedef struct packed {
    logic [7:0] line;
    logic [1:0] win;
    logic       full;
    logic       inv;
  } res_t;

  board_scan_ctrl #(
    .CELL_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cell_data  (cell_data),
    .sel        (sel),
    .busy       (busy),
    .done       (done),
    .winner     (winner),
    .win_line   (win_line),
    .board_full (board_full),
    .invalid    (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 9:1 cell mux seen by the DUT.
  always_comb begin
    cell_data = 8'hxx;
    if (sel < 4'd9) cell_data = board[sel];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // 01 if the three cells all hold X, 10 if all hold O, else 00.
  function automatic logic [1:0] owner(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
    if (a == 8'h01 && b == 8'h01 && c == 8'h01) return 2'b01;
    if (a == 8'h02 && b == 8'h02 && c == 8'h02) return 2'b10;
    return 2'b00;
  endfunction

  function automatic res_t model(input logic [7:0] b [9]);
    res_t       r;
    logic [1:0] o [8];
    for (int i = 0; i < 3; i++) begin
      o[i]     = owner(b[3*i], b[3*i+1], b[3*i+2]);
      o[3 + i] = owner(b[i], b[i+3], b[i+6]);
    end
    o[6] = owner(b[0], b[4], b[8]);
    o[7] = owner(b[2], b[4], b[6]);
    r = '0;
    for (int l = 0; l < 8; l++) begin
      r.line[l] = (o[l] != 2'b00);
      r.win     = r.win | o[l];
    end
    r.full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (b[i] == 8'h00) r.full = 1'b0;
      if (b[i] > 8'h02) r.inv = 1'b1;
    end
    return r;
  endfunction

  task automatic set_board(input logic [71:0] cells);
    for (int i = 0; i < 9; i++) board[i] = cells[8*(8-i) +: 8];
  endtask

  // Issue start, watch sel/busy/done cycle by cycle, then check results.
  task automatic run_scan(input string tag, input bit watch_sel);
    res_t exp;
    int   lat;
    int   pulses;
    exp = model(board);
    lat = -1;
    pulses = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 13; n++) begin
      if (watch_sel && n <= 9) begin
        check_eq({tag, "_sel"}, 32'(sel), (n == 9) ? 32'd0 : 32'(n));
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      end
      if (watch_sel && n == 10) check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
      if (done) begin
        pulses++;
        if (lat < 0) lat = n;
      end
      @(negedge clk);
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd10);
    check_eq({tag, "_pulses"}, 32'(pulses), 32'd1);
    check_eq({tag, "_winner"}, 32'(winner), 32'(exp.win));
    check_eq({tag, "_win_line"}, 32'(win_line), 32'(exp.line));
    check_eq({tag, "_full"}, 32'(board_full), 32'(exp.full));
    check_eq({tag, "_invalid"}, 32'(invalid), 32'(exp.inv));
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_sel"}, 32'(sel), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_winner"}, 32'(winner), 32'd0);
    check_eq({tag, "_win_line"}, 32'(win_line), 32'd0);
    check_eq({tag, "_full"}, 32'(board_full), 32'd0);
    check_eq({tag, "_invalid"}, 32'(invalid), 32'd0);
  endtask

  initial begin
    int pulses;
    int waited;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    set_board(72'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_cleared("reset");

    set_board({8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00});
    run_scan("x_row", 1'b1);

    set_board({8'h01, 8'h02, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h01, 8'h01});
    run_scan("draw", 1'b0);

    set_board({8'h02, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h02});
    run_scan("o_diag", 1'b0);

    set_board({8'h01, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00});
    run_scan("illegal", 1'b0);

    // Start pulses while busy must neither queue nor restart the scan.
    set_board({8'h02, 8'h02, 8'h02, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00});
    pulses = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 25; n++) begin
      start = (n == 2 || n == 9);
      if (done) pulses++;
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("busy_start_pulses", 32'(pulses), 32'd1);
    check_eq("busy_start_winner", 32'(winner), 32'd2);
    run_scan("fresh_start", 1'b0);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 9; i++) begin
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 6) board[i] = 8'h00;
        else if (r < 12) board[i] = 8'h01;
        else if (r < 18) board[i] = 8'h02;
        else board[i] = 8'(3 + $urandom_range(0, 252));
      end
      run_scan($sformatf("rand%0d", t), (t % 10) == 0);
    end

    // Reset mid-scan once sel reaches 4: abort with no done pulse.
    set_board({8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (sel != 4'd4 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("mid_reset_reach_sel4", 32'(sel), 32'd4);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_cleared("mid_reset");
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check_eq("mid_reset_no_done", 32'(pulses), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
